// File: rtl/pong_pkg.sv
// Shared Pong constants: playfield size, bus widths and the paddle state encoding.
package pong_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int COORD_W  = 10;
    localparam int SIZE_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN
    } paddle_state_t;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer that brings a raw asynchronous button into the clk domain.
module btn_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/pong_paddle_ctrl.sv
// Per-player paddle position generator: moves the paddle once per frame tick and clamps it.
// Define PONG_PADDLE_ACCEL_EN to enable hold-to-accelerate speed ramping.
module pong_paddle_ctrl
    import pong_pkg::*;
#(
    parameter int X_POS      = 16,
    parameter int Y_INIT     = 208,
    parameter int HEIGHT     = 64,
    parameter int WIDTH      = 8,
    parameter int Y_MIN      = 0,
    parameter int Y_MAX      = V_ACTIVE,
    parameter int SPEED_BASE = 2
`ifdef PONG_PADDLE_ACCEL_EN
    ,
    parameter int SPEED_MAX    = 8,
    parameter int ACCEL_FRAMES = 4
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_tick,
    input  logic                btn_up,
    input  logic                btn_down,
    output logic [COORD_W-1:0]  x_paddle,
    output logic [COORD_W-1:0]  y_paddle,
    output logic [SIZE_W-1:0]   height_paddle,
    output logic [SIZE_W-1:0]   width_paddle,
    output logic                at_limit,
    output logic                moving
);

    localparam logic [COORD_W:0]   STEP_BASE = (COORD_W + 1)'(SPEED_BASE);
    localparam logic [COORD_W:0]   Y_LOW     = (COORD_W + 1)'(Y_MIN);
    localparam logic [COORD_W:0]   Y_HIGH    = (COORD_W + 1)'(Y_MAX - HEIGHT);
    localparam logic [COORD_W-1:0] Y_LOW_C   = COORD_W'(Y_MIN);
    localparam logic [COORD_W-1:0] Y_HIGH_C  = COORD_W'(Y_MAX - HEIGHT);
    localparam logic [COORD_W-1:0] Y_RESET   = COORD_W'(Y_INIT);

    logic                up_sync;
    logic                down_sync;
    paddle_state_t       state_q;
    paddle_state_t       state_d;
    logic [COORD_W-1:0]  y_q;
    logic [COORD_W-1:0]  y_d;
    logic [COORD_W:0]    step;
    logic [COORD_W:0]    y_up;
    logic [COORD_W:0]    y_dn;

`ifdef PONG_PADDLE_ACCEL_EN
    localparam logic [SIZE_W-1:0] SPEED_BASE_W = SIZE_W'(SPEED_BASE);
    localparam logic [SIZE_W-1:0] SPEED_MAX_W  = SIZE_W'(SPEED_MAX);
    localparam logic [SIZE_W-1:0] HOLD_LAST    = SIZE_W'(ACCEL_FRAMES - 1);

    logic [SIZE_W-1:0] speed_q;
    logic [SIZE_W-1:0] speed_d;
    logic [SIZE_W-1:0] hold_q;
    logic [SIZE_W-1:0] hold_d;
`endif

    btn_sync u_sync_up (
        .clk      (clk),
        .reset    (reset),
        .async_in (btn_up),
        .sync_out (up_sync)
    );

    btn_sync u_sync_down (
        .clk      (clk),
        .reset    (reset),
        .async_in (btn_down),
        .sync_out (down_sync)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            y_q     <= Y_RESET;
`ifdef PONG_PADDLE_ACCEL_EN
            speed_q <= SPEED_BASE_W;
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
`ifdef PONG_PADDLE_ACCEL_EN
            speed_q <= speed_d;
            hold_q  <= hold_d;
`endif
        end
    end

    // Everything advances only on the frame tick, so the paddle is stable across a frame.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        step    = STEP_BASE;
`ifdef PONG_PADDLE_ACCEL_EN
        speed_d = speed_q;
        hold_d  = hold_q;
        step    = {{(COORD_W + 1 - SIZE_W){1'b0}}, speed_q};
`endif
        if (frame_tick) begin
            case ({up_sync, down_sync})
                2'b10:   state_d = MOVE_UP;
                2'b01:   state_d = MOVE_DOWN;
                default: state_d = IDLE;
            endcase
`ifdef PONG_PADDLE_ACCEL_EN
            // A fresh press or a reversal restarts the ramp and moves at base speed this tick.
            if (state_d == IDLE || state_d != state_q) begin
                speed_d = SPEED_BASE_W;
                hold_d  = '0;
                step    = STEP_BASE;
            end else if (hold_q + 8'd1 >= HOLD_LAST) begin
                hold_d = '0;
                if (speed_q < SPEED_MAX_W)
                    speed_d = speed_q + 8'd1;
            end else begin
                hold_d = hold_q + 8'd1;
            end
`endif
        end

        y_up = {1'b0, y_q} - step;
        y_dn = {1'b0, y_q} + step;

        // Bit COORD_W of y_up flags an underflow past row zero.
        if (frame_tick) begin
            if (state_d == MOVE_UP)
                y_d = (y_up[COORD_W] || y_up < Y_LOW) ? Y_LOW_C : y_up[COORD_W-1:0];
            else if (state_d == MOVE_DOWN)
                y_d = (y_dn > Y_HIGH) ? Y_HIGH_C : y_dn[COORD_W-1:0];
        end
    end

    assign x_paddle      = COORD_W'(X_POS);
    assign y_paddle      = y_q;
    assign height_paddle = SIZE_W'(HEIGHT);
    assign width_paddle  = SIZE_W'(WIDTH);
    assign at_limit      = (y_q == Y_LOW_C) || (y_q == Y_HIGH_C);
    assign moving        = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);

endmodule

// File: tb/tb_pong_paddle_ctrl.sv
// Scoreboard bench for pong_paddle_ctrl; expected values follow the PONG_PADDLE_ACCEL_EN build setting.
module tb_pong_paddle_ctrl;

    typedef struct {
        logic [9:0] y;
        logic       mov;
        logic       lim;
    } expect_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [9:0] x_paddle;
    logic [9:0] y_paddle;
    logic [7:0] height_paddle;
    logic [7:0] width_paddle;
    logic       at_limit;
    logic       moving;

    expect_t expQ[$];
    int      checks = 0;
    int      errors = 0;

    // Hand-computed accelerated climb from 208: speed 2,2,2,2,3,3,3,4,... capped at 8.
    int upSeq[35] = '{206, 204, 202, 200, 197, 194, 191, 187, 183, 179,
                      174, 169, 164, 158, 152, 146, 139, 132, 125, 117,
                      109, 101,  93,  85,  77,  69,  61,  53,  45,  37,
                       29,  21,  13,   5,   0};

    pong_paddle_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .x_paddle      (x_paddle),
        .y_paddle      (y_paddle),
        .height_paddle (height_paddle),
        .width_paddle  (width_paddle),
        .at_limit      (at_limit),
        .moving        (moving)
    );

    always #5 clk = ~clk;

    task automatic pushExpect(input int y, input logic mov);
        expect_t e;
        e.y   = 10'(y);
        e.mov = mov;
        e.lim = (y == 0) || (y == 416);
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic up, input logic down, input int expY, input logic expMov);
        @(negedge clk);
        btn_up   = up;
        btn_down = down;
        repeat (3) @(negedge clk);
        frame_tick = 1'b1;
        pushExpect(expY, expMov);
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic applyReset(input logic withTick);
        @(negedge clk);
        reset      = 1'b1;
        frame_tick = withTick;
        pushExpect(208, 1'b0);
        @(negedge clk);
        reset      = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic checkOutput(input expect_t e);
        checks++;
        if (y_paddle !== e.y) begin
            errors++;
            $display("[TB] FAIL y_paddle: got %0d expected %0d at %0t", y_paddle, e.y, $time);
        end
        checks++;
        if (moving !== e.mov) begin
            errors++;
            $display("[TB] FAIL moving: got %b expected %b at %0t", moving, e.mov, $time);
        end
        checks++;
        if (at_limit !== e.lim) begin
            errors++;
            $display("[TB] FAIL at_limit: got %b expected %b at %0t", at_limit, e.lim, $time);
        end
        checks++;
        if (x_paddle !== 10'd16 || height_paddle !== 8'd64 || width_paddle !== 8'd8) begin
            errors++;
            $display("[TB] FAIL constants: got x=%0d h=%0d w=%0d expected 16/64/8",
                     x_paddle, height_paddle, width_paddle);
        end
    endtask

    // Monitor: every tick or reset cycle is an observable update; compare it half a cycle later.
    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            if (frame_tick || reset) begin
                @(negedge clk);
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_update: got y=%0d with no expectation queued", y_paddle);
                end else begin
                    e = expQ.pop_front();
                    checkOutput(e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: got no completion, expected finish before %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int nRun;
        int expY;
`ifdef PONG_PADDLE_ACCEL_EN
        int downSeq[6] = '{208, 210, 212, 214, 217, 220};
        int revY  = 218;
        int revY2 = 216;
        nRun = 35;
`else
        int downSeq[6] = '{208, 210, 212, 214, 216, 218};
        int revY  = 216;
        int revY2 = 214;
        nRun = 104;
`endif
        $display("[TB] starting");
        applyReset(1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 208, 1'b0);

        // Short press entirely between ticks must leave no trace.
        @(negedge clk);
        btn_up = 1'b1;
        @(negedge clk);
        btn_up = 1'b0;
        applyStimulus(1'b0, 1'b0, 208, 1'b0);

        for (int k = 0; k < nRun; k++) begin
`ifdef PONG_PADDLE_ACCEL_EN
            expY = upSeq[k];
`else
            expY = (208 - 2 * (k + 1) < 0) ? 0 : 208 - 2 * (k + 1);
`endif
            applyStimulus(1'b1, 1'b0, expY, 1'b1);
        end
        for (int i = 0; i < 2; i++)
            applyStimulus(1'b1, 1'b0, 0, 1'b1);

        applyReset(1'b0);
        for (int k = 0; k < nRun; k++) begin
`ifdef PONG_PADDLE_ACCEL_EN
            expY = 416 - upSeq[k];
`else
            expY = (208 + 2 * (k + 1) > 416) ? 416 : 208 + 2 * (k + 1);
`endif
            applyStimulus(1'b0, 1'b1, expY, 1'b1);
        end
        for (int i = 0; i < 2; i++)
            applyStimulus(1'b0, 1'b1, 416, 1'b1);

        applyReset(1'b0);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 1'b1, 208, 1'b0);
        applyStimulus(1'b1, 1'b0, 206, 1'b1);

        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, 1'b1, downSeq[i], 1'b1);
        applyStimulus(1'b1, 1'b0, revY, 1'b1);
        applyStimulus(1'b1, 1'b0, revY2, 1'b1);

        applyReset(1'b1);
        applyStimulus(1'b1, 1'b0, 206, 1'b1);
        applyStimulus(1'b1, 1'b0, 204, 1'b1);
        applyStimulus(1'b0, 1'b0, 204, 1'b0);

        repeat (4) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
